command_reader_controller: RTL and testbench

//  FSM that sequences the command-reader datapath (word register + timeout counter).

---
 rtl/cmd_reader_pkg.sv | 31 +++
 rtl/command_reader_controller.sv | 128 ++++++++++++
 tb/tb_command_reader_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cmd_reader_pkg.sv
// Shared types and constants for the command reader.
// Holds the FSM state encoding plus the word/timer select codes.
package cmd_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_MAX,
    S_LOAD,
    S_WAIT_TX
  } state_t;

  localparam logic [1:0] WS_HOLD  = 2'b00;
  localparam logic [1:0] WS_MAX   = 2'b01;
  localparam logic [1:0] WS_TRUE  = 2'b10;
  localparam logic [1:0] WS_FALSE = 2'b11;

  localparam logic [1:0] TS_CLEAR = 2'b00;
  localparam logic [1:0] TS_COUNT = 2'b01;
  localparam logic [1:0] TS_HOLD  = 2'b10;

  localparam logic [3:0] OP_READ_MAX_C = 4'h1;
  localparam logic [3:0] OP_STATUS_C   = 4'h2;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/command_reader_controller.sv
// Command reader FSM: decodes host bytes, drives the capture
// request, word/timer selects and the UART transmit strobe.
module command_reader_controller
  import cmd_reader_pkg::*;
#(
  parameter int         NUM_CHANNELS = 4,
  parameter logic [3:0] OP_READ_MAX  = OP_READ_MAX_C,
  parameter logic [3:0] OP_STATUS    = OP_STATUS_C
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  output logic       cmd_busy,
  output logic       max_req,
  output logic [2:0] ch_sel,
  input  logic       max_valid,
  input  logic       ping_flag,
  input  logic       timeout,
  output logic [1:0] timer_sel,
  output logic [1:0] word_sel,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] err_count
);

  state_t     state_q;
  logic [7:0] cmd_q;
  logic [7:0] err_q;
  logic       busy_q;
  logic       max_req_q;
  logic       tx_start_q;
  logic [1:0] timer_sel_q;
  logic [1:0] word_sel_q;

  logic is_rd;
  logic is_st;
  logic ch_ok;

  assign is_rd = (cmd_q[7:4] == OP_READ_MAX);
  assign is_st = (cmd_q[7:4] == OP_STATUS);
  assign ch_ok = (int'(cmd_q[3:0]) < NUM_CHANNELS);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'h00;
      err_q       <= 8'h00;
      busy_q      <= 1'b0;
      max_req_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      timer_sel_q <= TS_CLEAR;
      word_sel_q  <= WS_HOLD;
    end else begin
      max_req_q <= 1'b0;
      tx_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          word_sel_q  <= WS_HOLD;
          timer_sel_q <= TS_CLEAR;
          if (cmd_valid) begin
            cmd_q   <= cmd;
            busy_q  <= 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q     <= S_LOAD;
          timer_sel_q <= TS_CLEAR;
          unique case (1'b1)
            is_rd && ch_ok: begin
              max_req_q   <= 1'b1;
              timer_sel_q <= TS_COUNT;
              state_q     <= S_WAIT_MAX;
            end
            is_st: begin
              word_sel_q <= ping_flag ? WS_TRUE : WS_FALSE;
            end
            default: begin
              word_sel_q <= WS_FALSE;
              err_q      <= sat_inc(err_q);
            end
          endcase
        end
        S_WAIT_MAX: begin
          // max_valid takes priority over a coincident timeout
          if (max_valid) begin
            word_sel_q  <= WS_MAX;
            timer_sel_q <= TS_CLEAR;
            state_q     <= S_LOAD;
          end else if (timeout) begin
            word_sel_q  <= WS_FALSE;
            timer_sel_q <= TS_CLEAR;
            err_q       <= sat_inc(err_q);
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          word_sel_q <= WS_HOLD;
          tx_start_q <= !tx_busy;
          state_q    <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          // pulse is already out this cycle: finish the transaction
          if (tx_start_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tx_start_q <= !tx_busy;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_busy  = busy_q;
  assign max_req   = max_req_q;
  assign ch_sel    = cmd_q[2:0];
  assign timer_sel = timer_sel_q;
  assign word_sel  = word_sel_q;
  assign tx_start  = tx_start_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_command_reader_controller.sv
// Directed bench for command_reader_controller: vector table
// plus hand sequences for TX back-pressure and error saturation.
module tb_command_reader_controller;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       cmd_busy;
  logic       max_req;
  logic [2:0] ch_sel;
  logic       max_valid;
  logic       ping_flag;
  logic       timeout;
  logic [1:0] timer_sel;
  logic [1:0] word_sel;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [7:0] c;
    logic       mv;
    logic       pf;
    logic       to;
    logic       tb;
    logic       busy;
    logic       mr;
    logic [1:0] ts;
    logic [1:0] ws;
    logic       tx;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[$];

  command_reader_controller dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_busy  (cmd_busy),
    .max_req   (max_req),
    .ch_sel    (ch_sel),
    .max_valid (max_valid),
    .ping_flag (ping_flag),
    .timeout   (timeout),
    .timer_sel (timer_sel),
    .word_sel  (word_sel),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(
    input logic rst, input logic cv, input logic [7:0] c,
    input logic mv, input logic pf, input logic to, input logic tb,
    input logic busy, input logic mr, input logic [1:0] ts,
    input logic [1:0] ws, input logic tx, input logic [7:0] err
  );
    vec_t v;
    v.rst = rst; v.cv = cv; v.c = c; v.mv = mv; v.pf = pf;
    v.to = to; v.tb = tb; v.busy = busy; v.mr = mr; v.ts = ts;
    v.ws = ws; v.tx = tx; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic idle_in();
    reset_b = 1'b1; cmd_valid = 1'b0; cmd = 8'h00;
    max_valid = 1'b0; ping_flag = 1'b0; timeout = 1'b0; tx_busy = 1'b0;
  endtask

  initial begin
    int n;
    idle_in();
    reset_b = 1'b0;

    // reset, reset-over-command
    add(0,0,8'h00,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,8'h20,1,1,1,0, 0,0,0,0,0,0);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,0);
    // STATUS with ping, then a dropped cmd in the tx_start cycle
    add(1,1,8'h20,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,8'h00,0,1,0,0, 1,0,0,2,0,0);
    add(1,0,8'h00,0,0,0,0, 1,0,0,0,1,0);
    add(1,1,8'h70,0,0,0,0, 0,0,0,0,0,0);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,0);
    // STATUS without ping
    add(1,1,8'h25,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,8'h00,0,0,0,0, 1,0,0,3,0,0);
    add(1,0,8'h00,0,0,0,0, 1,0,0,0,1,0);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,0);
    // READ_MAX ch2, result 5 edges after the command
    add(1,1,8'h12,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,8'h00,0,0,0,0, 1,1,1,0,0,0);
    add(1,0,8'h00,0,0,0,0, 1,0,1,0,0,0);
    add(1,0,8'h00,0,0,0,0, 1,0,1,0,0,0);
    add(1,0,8'h00,0,0,0,0, 1,0,1,0,0,0);
    add(1,0,8'h00,1,0,0,0, 1,0,0,1,0,0);
    add(1,0,8'h00,0,0,0,0, 1,0,0,0,1,0);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,0);
    // READ_MAX ch3 times out
    add(1,1,8'h13,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,8'h00,0,0,0,0, 1,1,1,0,0,0);
    add(1,0,8'h00,0,0,1,0, 1,0,0,3,0,1);
    add(1,0,8'h00,0,0,0,0, 1,0,0,0,1,1);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,1);
    // max_valid and timeout together
    add(1,1,8'h11,0,0,0,0, 1,0,0,0,0,1);
    add(1,0,8'h00,0,0,0,0, 1,1,1,0,0,1);
    add(1,0,8'h00,1,0,1,0, 1,0,0,1,0,1);
    add(1,0,8'h00,0,0,0,0, 1,0,0,0,1,1);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,1);
    // bad channel
    add(1,1,8'h16,0,0,0,0, 1,0,0,0,0,1);
    add(1,0,8'h00,0,0,0,0, 1,0,0,3,0,2);
    add(1,0,8'h00,0,0,0,0, 1,0,0,0,1,2);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,2);
    // bad opcode
    add(1,1,8'h70,0,0,0,0, 1,0,0,0,0,2);
    add(1,0,8'h00,0,0,0,0, 1,0,0,3,0,3);
    add(1,0,8'h00,0,0,0,0, 1,0,0,0,1,3);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,3);
    // reset in WAIT_MAX, coincident with max_valid
    add(1,1,8'h10,0,0,0,0, 1,0,0,0,0,3);
    add(1,0,8'h00,0,0,0,0, 1,1,1,0,0,3);
    add(1,0,8'h00,0,0,0,0, 1,0,1,0,0,3);
    add(0,0,8'h00,1,0,0,0, 0,0,0,0,0,0);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,0);
    add(1,0,8'h00,0,0,0,0, 0,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset_b   = tbl[i].rst;
      cmd_valid = tbl[i].cv;
      cmd       = tbl[i].c;
      max_valid = tbl[i].mv;
      ping_flag = tbl[i].pf;
      timeout   = tbl[i].to;
      tx_busy   = tbl[i].tb;
      step();
      chk($sformatf("v%0d cmd_busy", i), int'(cmd_busy), int'(tbl[i].busy));
      chk($sformatf("v%0d max_req", i), int'(max_req), int'(tbl[i].mr));
      chk($sformatf("v%0d timer_sel", i), int'(timer_sel), int'(tbl[i].ts));
      chk($sformatf("v%0d word_sel", i), int'(word_sel), int'(tbl[i].ws));
      chk($sformatf("v%0d tx_start", i), int'(tx_start), int'(tbl[i].tx));
      chk($sformatf("v%0d err_count", i), int'(err_count), int'(tbl[i].err));
    end

    // TX held busy for 20 cycles; a command during that is ignored
    idle_in();
    tx_busy = 1'b1;
    cmd_valid = 1'b1; cmd = 8'h20;
    step();
    cmd_valid = 1'b0; ping_flag = 1'b1;
    step();
    chk("txb load word_sel", int'(word_sel), 2);
    ping_flag = 1'b0;
    step();
    chk("txb first tx_start", int'(tx_start), 0);
    for (int i = 0; i < 20; i++) begin
      cmd_valid = (i == 5);
      cmd = 8'h70;
      step();
      chk($sformatf("txb%0d tx_start", i), int'(tx_start), 0);
      chk($sformatf("txb%0d cmd_busy", i), int'(cmd_busy), 1);
    end
    cmd_valid = 1'b0;
    tx_busy = 1'b0;
    step();
    chk("txb release tx_start", int'(tx_start), 1);
    step();
    chk("txb done tx_start", int'(tx_start), 0);
    chk("txb done cmd_busy", int'(cmd_busy), 0);
    chk("txb err_count", int'(err_count), 0);

    // saturate the error counter
    idle_in();
    for (int i = 1; i <= 300; i++) begin
      cmd_valid = 1'b1; cmd = 8'h73;
      step();
      cmd_valid = 1'b0;
      if (i == 1) chk("sat ch_sel", int'(ch_sel), 3);
      step();
      step();
      step();
      n = (i > 255) ? 255 : i;
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        chk($sformatf("sat err_count after %0d", i), int'(err_count), n);
    end
    chk("sat cmd_busy", int'(cmd_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
